// File: rtl/aes128_round_seq.sv
// Iterative AES-128 encryption sequencer driving an external combinational round datapath.
// Optional abort input enabled by defining AES_SEQ_ABORT_EN.
module aes128_round_seq #(
   parameter int NR = 10,
   parameter int RW = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [0:127] in_data,
   input  logic [0:127] in_key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [0:127] out_data,
   output logic [0:127] rd_state,
   output logic [0:127] rd_key,
   output logic [31:0]  rd_rcon,
   output logic         rd_final,
   input  logic [0:127] rd_state_nxt,
   input  logic [0:127] rd_key_nxt,
`ifdef AES_SEQ_ABORT_EN
   input  logic         abort,
`endif
   output logic         busy,
   output logic [1:0]   dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
   // valid never waits on ready, and data is held stable while valid is high without ready.

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      DONE  = 2'd2
   } fsm_t;

   fsm_t          fsm;
   logic [0:127]  state_reg;
   logic [0:127]  key_reg;
   logic [RW-1:0] round;
   logic [7:0]    rcon;
   logic          abort_req;

`ifdef AES_SEQ_ABORT_EN
   assign abort_req = abort;
`else
   assign abort_req = 1'b0;
`endif

   // Rcon advances by doubling in GF(2^8) each round.
   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm       <= IDLE;
         state_reg <= '0;
         key_reg   <= '0;
         out_data  <= '0;
         round     <= '0;
         rcon      <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else if (abort_req && fsm != IDLE) begin
         fsm       <= IDLE;
         round     <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (fsm)
            IDLE: begin
               if (in_valid && in_ready) begin
                  state_reg <= in_data ^ in_key;
                  key_reg   <= in_key;
                  round     <= RW'(1);
                  rcon      <= 8'h01;
                  in_ready  <= 1'b0;
                  busy      <= 1'b1;
                  fsm       <= ROUND;
               end
            end
            ROUND: begin
               state_reg <= rd_state_nxt;
               key_reg   <= rd_key_nxt;
               rcon      <= xtime(rcon);
               if (round == RW'(NR)) begin
                  out_data  <= rd_state_nxt;
                  out_valid <= 1'b1;
                  busy      <= 1'b0;
                  fsm       <= DONE;
               end else begin
                  round <= round + RW'(1);
               end
            end
            DONE: begin
               // in_ready stays low here so a new block waits for the next IDLE cycle.
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  fsm       <= IDLE;
               end
            end
            default: begin
               fsm       <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

   assign rd_state  = state_reg;
   assign rd_key    = key_reg;
   assign rd_rcon   = (fsm == ROUND) ? {rcon, 24'h000000} : 32'h0;
   assign rd_final  = (fsm == ROUND) && (round == RW'(NR));
   assign dbg_state = fsm;

endmodule
